// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: tags each memory response with its fetch PC, queues it
// for decode, and steers the PC register to replay dropped fetches or follow a flush.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [31:0]            PC,
  input  logic [31:0]            IMemData,
  input  logic                   Flush,
  input  logic [31:0]            FlushTarget,
  input  logic                   InstrReady,
  output logic                   InstrValid,
  output logic [31:0]            Instr,
  output logic [31:0]            InstrPC,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   PCWrite,
  output logic [31:0]            PCNext,
  output logic                   Replay
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  // Stage p1: the response arriving this cycle belongs to last cycle's PC.
  logic          vld_p1;
  logic [31:0]   resp_pc_p1;

  logic          full;
  logic          deq;
  logic          enq;
  logic          drop;

  assign full       = (count == FULL_COUNT);
  assign InstrValid = (count != '0);
  assign Instr      = instr_mem[rd_ptr];
  assign InstrPC    = pc_mem[rd_ptr];
  assign Count      = count;

  assign deq  = InstrValid & InstrReady & ~Flush;
  assign enq  = vld_p1 & ~Flush & (~full | deq);
  assign drop = vld_p1 & ~Flush & full & ~deq;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1     <= 1'b0;
      resp_pc_p1 <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      // A redirect (flush or replay) makes the next response wrong-path; squash it.
      vld_p1     <= ~(Flush | drop);
      resp_pc_p1 <= PC;
      if (Flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          instr_mem[wr_ptr] <= IMemData;
          pc_mem[wr_ptr]    <= resp_pc_p1;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // The PC register cannot hold, so a dropped response is recovered by reloading its PC.
  always_comb begin
    PCWrite = 1'b0;
    PCNext  = '0;
    Replay  = 1'b0;
    if (!Reset) begin
      if (Flush) begin
        PCWrite = 1'b1;
        PCNext  = FlushTarget;
      end else if (drop) begin
        PCWrite = 1'b1;
        PCNext  = resp_pc_p1;
        Replay  = 1'b1;
      end
    end
  end

endmodule
